// File: rtl/stage_sequencer_if.sv
// rtl/stage_sequencer_if.sv - bundle of control, status and per-stage signals of the stage sequencer
//
// Purpose: groups every stage_sequencer signal except clock and reset.
// Ports (signals):
//   run          sequencer input, level request to keep executing rounds
//   stage_mask   sequencer input, bit k-1 enables stage k
//   stage_done   sequencer input, done level from stage k
//   stage_exit   sequencer input, early-termination flag from stage k
//   stage_wr_req sequencer input, memory write request from stage k
//   stage_en     sequencer output, one-hot active-stage enable
//   stage_nrst   sequencer output, active-low reset to all stages
//   addr_select  sequencer output, address mux select (0 = no stage)
//   wr_en        sequencer output, memory write enable
//   busy         sequencer output, high outside IDLE
//   round_done   sequencer output, one-cycle pulse at round end
//   exit_stage   sequencer output, stage that ended the last round early
//   timeout      sequencer output, watchdog expiry pulse
//   round_count  sequencer output, completed round count
// Modports: master = sequencer side, slave = stage/controller side.
interface stage_sequencer_if #(
  parameter int NUM_STAGES = 7
);
  logic                  run;
  logic [NUM_STAGES-1:0] stage_mask;
  logic [NUM_STAGES-1:0] stage_done;
  logic [NUM_STAGES-1:0] stage_exit;
  logic [NUM_STAGES-1:0] stage_wr_req;
  logic [NUM_STAGES-1:0] stage_en;
  logic                  stage_nrst;
  logic [2:0]            addr_select;
  logic                  wr_en;
  logic                  busy;
  logic                  round_done;
  logic [2:0]            exit_stage;
  logic                  timeout;
  logic [15:0]           round_count;

  modport master (
    input  run, stage_mask, stage_done, stage_exit, stage_wr_req,
    output stage_en, stage_nrst, addr_select, wr_en, busy, round_done,
           exit_stage, timeout, round_count
  );

  modport slave (
    output run, stage_mask, stage_done, stage_exit, stage_wr_req,
    input  stage_en, stage_nrst, addr_select, wr_en, busy, round_done,
           exit_stage, timeout, round_count
  );
endinterface

// File: rtl/stage_sequencer.sv
// rtl/stage_sequencer.sv - round-based sequencer that enables pipeline stages one at a time
//
// Purpose: each round clears all stages, then walks the enabled stages in
// ascending order, handing the address mux and memory write enable to the
// active stage until it reports done, exits early, or its watchdog expires.
// Ports:
//   clock  single clock, rising edge
//   rst    asynchronous active-high reset
//   bus    stage_sequencer_if.master (run/mask/done/exit/wr_req in,
//          stage_en/stage_nrst/addr_select/wr_en/status out)
// Parameters: NUM_STAGES (<= 7, addr_select is 3 bits), CLEAR_CYCLES (>= 1),
// TIMEOUT (cycles a stage may stay active without done).
module stage_sequencer #(
  parameter int NUM_STAGES   = 7,
  parameter int CLEAR_CYCLES = 2,
  parameter int TIMEOUT      = 1024
) (
  input  logic              clock,
  input  logic              rst,
  stage_sequencer_if.master bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_END   = 2'd3;

  localparam int CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLEAR_CYCLES - 1);
  localparam logic [15:0]      WD_LAST  = 16'(TIMEOUT - 1);

  logic [1:0]            state;
  logic [CLR_W-1:0]      clr_cnt;
  logic [NUM_STAGES-1:0] mask_q;
  logic [2:0]            cur;
  logic [15:0]           wdog;
  logic [2:0]            exit_q;
  logic                  timeout_q;
  logic [15:0]           count_q;

  logic [NUM_STAGES-1:0] cur_bit;
  logic                  cur_done;
  logic                  cur_exit;
  logic [2:0]            nxt_stage;
  logic [2:0]            first_stage;
  logic                  in_run;

  // Lowest enabled stage strictly above 'from'; 0 when none remains.
  function automatic logic [2:0] next_enabled(input logic [NUM_STAGES-1:0] m,
                                              input logic [2:0] from);
    logic [2:0] r;
    r = 3'd0;
    for (int i = NUM_STAGES; i >= 1; i--) begin
      if (i > int'(from) && m[i-1]) r = 3'(i);
    end
    return r;
  endfunction

  always_comb begin
    cur_bit = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      cur_bit[k] = (int'(cur) == k + 1);
    end
  end

  assign in_run      = (state == S_RUN);
  // Only the active stage's done/exit bits are looked at.
  assign cur_done    = |(bus.stage_done & cur_bit);
  assign cur_exit    = |(bus.stage_exit & cur_bit);
  assign nxt_stage   = next_enabled(mask_q, cur);
  assign first_stage = next_enabled(bus.stage_mask, 3'd0);

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      clr_cnt   <= '0;
      mask_q    <= '0;
      cur       <= 3'd0;
      wdog      <= 16'd0;
      exit_q    <= 3'd0;
      timeout_q <= 1'b0;
      count_q   <= 16'd0;
    end else begin
      timeout_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.run) begin
            state   <= S_CLEAR;
            clr_cnt <= '0;
          end
        end
        S_CLEAR: begin
          if (clr_cnt == CLR_LAST) begin
            mask_q <= bus.stage_mask;
            wdog   <= 16'd0;
            if (first_stage == 3'd0) begin
              state  <= S_END;
              exit_q <= 3'd0;
            end else begin
              state <= S_RUN;
              cur   <= first_stage;
            end
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        S_RUN: begin
          // done is checked first so it wins over a same-cycle watchdog expiry
          if (cur_done) begin
            wdog <= 16'd0;
            if (cur_exit) begin
              state  <= S_END;
              exit_q <= cur;
            end else if (nxt_stage == 3'd0) begin
              state  <= S_END;
              exit_q <= 3'd0;
            end else begin
              cur <= nxt_stage;
            end
          end else if (wdog == WD_LAST) begin
            timeout_q <= 1'b1;
            wdog      <= 16'd0;
            state     <= S_END;
            exit_q    <= cur;
          end else begin
            wdog <= wdog + 16'd1;
          end
        end
        S_END: begin
          if (exit_q == 3'd0) count_q <= count_q + 16'd1;
          cur     <= 3'd0;
          clr_cnt <= '0;
          state   <= bus.run ? S_CLEAR : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.stage_en    = in_run ? cur_bit : '0;
  assign bus.addr_select = in_run ? cur : 3'd0;
  assign bus.wr_en       = in_run & (|(bus.stage_wr_req & cur_bit));
  // Stages are held in reset only in IDLE and CLEAR, so the low time between
  // back-to-back rounds is exactly CLEAR_CYCLES.
  assign bus.stage_nrst  = (state == S_RUN) || (state == S_END);
  assign bus.busy        = (state != S_IDLE);
  assign bus.round_done  = (state == S_END);
  assign bus.timeout     = timeout_q;
  assign bus.exit_stage  = exit_q;
  assign bus.round_count = count_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// tb/tb_stage_sequencer.sv - self-checking bench for stage_sequencer
module tb_stage_sequencer;
  localparam int NS  = 7;
  localparam int TMO = 8;

  logic clock;
  logic rst;
  stage_sequencer_if #(.NUM_STAGES(NS)) bus();

  stage_sequencer #(.NUM_STAGES(NS), .CLEAR_CYCLES(2), .TIMEOUT(TMO)) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [6:0]  mask;
    logic [6:0]  exitv;
    int          delay;
    int          slow_stage;
    int          slow_delay;
    int          wrmode;
    bit          twice;
    logic [27:0] seq;      // visited stages, first in the top nibble
    logic [2:0]  exp_exit;
    logic        exp_to;
  } vec_t;

  vec_t       vecs[9];
  int         errors = 0;
  int         checks = 0;
  logic [15:0] model_count = 16'd0;
  logic [2:0] exp_q[$];

  int         dly[NS];
  int         act_cnt[NS];
  logic [6:0] done_r;
  int         wrmode;
  bit         tog;
  int         cyc;
  int         en_cyc;
  logic [2:0] prev_addr;
  logic [2:0] cur_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_seq(input logic [27:0] s);
    for (int i = 6; i >= 0; i--) begin
      logic [3:0] d;
      d = s[i*4 +: 4];
      if (d != 4'd0) exp_q.push_back(d[2:0]);
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_stage_en", bus.stage_en, 0);
    chk("rst_stage_nrst", bus.stage_nrst, 0);
    chk("rst_addr_select", bus.addr_select, 0);
    chk("rst_wr_en", bus.wr_en, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_round_done", bus.round_done, 0);
    chk("rst_timeout", bus.timeout, 0);
    chk("rst_exit_stage", bus.exit_stage, 0);
    chk("rst_round_count", bus.round_count, 0);
  endtask

  task automatic wait_busy(output bit found);
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (bus.busy) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_vector(input vec_t v);
    int nr;
    bit found;
    for (int k = 0; k < NS; k++) dly[k] = v.delay;
    if (v.slow_stage != 0) dly[v.slow_stage-1] = v.slow_delay;
    wrmode         = v.wrmode;
    bus.stage_mask = v.mask;
    bus.stage_exit = v.exitv;
    nr = v.twice ? 2 : 1;
    bus.run = 1'b1;
    wait_busy(found);
    chk("start_busy", found, 1);
    for (int r = 0; r < nr; r++) begin
      push_seq(v.seq);
      // run is dropped mid-round; the round must still complete
      if (r == nr - 1) bus.run = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 300; i++) begin
        @(negedge clock);
        if (bus.round_done) begin
          found = 1'b1;
          break;
        end
      end
      chk("round_done_seen", found, 1);
      chk("exit_stage", bus.exit_stage, v.exp_exit);
      chk("timeout_pulse", bus.timeout, v.exp_to);
      if (v.exp_exit == 3'd0) model_count = model_count + 16'd1;
      @(negedge clock);
      chk("round_count", bus.round_count, model_count);
      chk("round_done_one_cycle", bus.round_done, 0);
      chk("timeout_one_cycle", bus.timeout, 0);
      chk("stages_left", exp_q.size(), 0);
      if (r < nr - 1) begin
        chk("restart_busy", bus.busy, 1);
        chk("restart_clear_nrst", bus.stage_nrst, 0);
      end else begin
        chk("idle_after_round", bus.busy, 0);
      end
    end
    @(negedge clock);
    chk("exit_stage_held", bus.exit_stage, v.exp_exit);
  endtask

  // Monitor first, then the stage responder, so input updates never race the checks.
  always @(negedge clock) begin
    if (rst) begin
      prev_addr = 3'd0;
      cur_exp   = 3'd0;
      done_r    = 7'd0;
      for (int k = 0; k < NS; k++) act_cnt[k] = 0;
      bus.stage_done   = 7'd0;
      bus.stage_wr_req = 7'd0;
    end else begin
      cyc++;
      if (bus.addr_select != prev_addr && bus.addr_select != 3'd0) begin
        en_cyc = cyc;
        if (exp_q.size() == 0) begin
          chk("unexpected_stage", bus.addr_select, 0);
          cur_exp = 3'd0;
        end else begin
          cur_exp = exp_q.pop_front();
          chk("stage_order", bus.addr_select, cur_exp);
        end
      end
      if (bus.addr_select == 3'd0) begin
        chk("stage_en_inactive", bus.stage_en, 0);
        chk("wr_en_inactive", bus.wr_en, 0);
      end else if (cur_exp != 3'd0) begin
        chk("stage_en_onehot", bus.stage_en, 7'd1 << (cur_exp - 3'd1));
        chk("stage_nrst_active", bus.stage_nrst, 1);
        chk("wr_en", bus.wr_en, bus.stage_wr_req[cur_exp - 3'd1]);
      end
      if (bus.timeout) chk("timeout_latency", cyc - en_cyc, TMO);
      prev_addr = bus.addr_select;

      for (int k = 0; k < NS; k++) begin
        if (bus.stage_en[k]) begin
          if (act_cnt[k] == dly[k]) done_r[k] = 1'b1;
          act_cnt[k]++;
        end else begin
          act_cnt[k] = 0;
          done_r[k]  = 1'b0;
        end
      end
      bus.stage_done = done_r;
      case (wrmode)
        1: bus.stage_wr_req = 7'($urandom);
        2: begin
          tog = ~tog;
          bus.stage_wr_req = 7'h7F ^ {3'b000, tog, 3'b000};
        end
        default: bus.stage_wr_req = 7'h7F;
      endcase
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit found;
    cyc = 0; en_cyc = 0; tog = 1'b0; wrmode = 0;
    for (int k = 0; k < NS; k++) dly[k] = 3;
    //                mask   exitv  dly slow sdly wr twice seq           exit to
    vecs[0] = '{7'h7F, 7'h00, 3, 0, 0,   2, 1'b1, 28'h1234567, 3'd0, 1'b0};
    vecs[1] = '{7'h7F, 7'h01, 3, 0, 0,   0, 1'b0, 28'h1000000, 3'd1, 1'b0};
    vecs[2] = '{7'h07, 7'h7C, 3, 0, 0,   0, 1'b0, 28'h1230000, 3'd3, 1'b0};
    vecs[3] = '{7'h7F, 7'h00, 3, 2, 255, 0, 1'b0, 28'h1200000, 3'd2, 1'b1};
    vecs[4] = '{7'h7F, 7'h00, 3, 2, 7,   1, 1'b0, 28'h1234567, 3'd0, 1'b0};
    vecs[5] = '{7'h52, 7'h2D, 0, 0, 0,   1, 1'b0, 28'h2570000, 3'd0, 1'b0};
    vecs[6] = '{7'h00, 7'h7F, 3, 0, 0,   0, 1'b0, 28'h0000000, 3'd0, 1'b0};
    vecs[7] = '{7'h40, 7'h40, 2, 0, 0,   1, 1'b0, 28'h7000000, 3'd7, 1'b0};
    vecs[8] = '{7'h7F, 7'h00, 2, 4, 5,   2, 1'b0, 28'h1234567, 3'd0, 1'b0};

    rst = 1'b1;
    bus.run = 1'b0;
    bus.stage_mask = 7'd0;
    bus.stage_exit = 7'd0;
    repeat (2) @(negedge clock);
    check_reset_outputs();
    rst = 1'b0;
    @(negedge clock);
    chk("idle_after_reset", bus.busy, 0);

    // Reset asserted while stage 5 is active
    bus.stage_mask = 7'h7F;
    bus.stage_exit = 7'h00;
    push_seq(28'h1234500);
    bus.run = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (bus.addr_select == 3'd5) begin
        found = 1'b1;
        break;
      end
    end
    chk("reach_stage5", found, 1);
    #1 rst = 1'b1;
    #1 check_reset_outputs();
    chk("abort_stages_seen", exp_q.size(), 0);
    exp_q.delete();
    bus.run = 1'b0;
    @(negedge clock);
    rst = 1'b0;
    @(negedge clock);
    chk("idle_after_abort", bus.busy, 0);
    chk("count_after_abort", bus.round_count, 0);

    for (int n = 0; n < 9; n++) run_vector(vecs[n]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/stage_sequencer.md
STAGE_SEQUENCER -- requirements
Module: stage_sequencer

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 7, meaning number of pipeline stages sequenced (stage k maps to addr_select value k, k = 1..NUM_STAGES).
REQ-002 SHALL have parameter CLEAR_CYCLES, default 2, meaning cycles that stage_nrst is held low between rounds.
REQ-003 SHALL have parameter TIMEOUT, default 1024, meaning the maximum number of cycles a stage may stay active without asserting done.
REQ-004 SHALL have the port: clock  input  1  the single clock; all logic is on its rising edge.
REQ-005 SHALL have the port: rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have the port: run  input  1  level request to keep executing rounds.
REQ-007 SHALL have the port: stage_mask  input  NUM_STAGES  bit k-1 high enables stage k; sampled at round start.
REQ-008 SHALL have the port: stage_done  input  NUM_STAGES  done level from stage k.
REQ-009 SHALL have the port: stage_exit  input  NUM_STAGES  early-termination flag from stage k (forAggregation / not-forwarding); qualified by stage_done.
REQ-010 SHALL have the port: stage_wr_req  input  NUM_STAGES  memory write request from stage k.
REQ-011 SHALL have the port: stage_en  output  NUM_STAGES  one-hot active-stage enable.
REQ-012 SHALL have the port: stage_nrst  output  1  active-low reset to all stages.
REQ-013 SHALL have the port: addr_select  output  3  address mux select; 0 when no stage is active.
REQ-014 SHALL have the port: wr_en  output  1  memory write enable.
REQ-015 SHALL have the port: busy  output  1  high outside IDLE.
REQ-016 SHALL have the port: round_done  output  1  one-cycle pulse at round end.
REQ-017 SHALL have the port: exit_stage  output  3  stage that ended the last round early; 0 = full completion.
REQ-018 SHALL have the port: timeout  output  1  one-cycle pulse when a stage exceeds TIMEOUT.
REQ-019 SHALL have the port: round_count  output  16  count of completed rounds.

Function
REQ-020 SHALL implement the states IDLE, CLEAR, RUN, END.
REQ-021 SHALL, in IDLE with run=1, go to CLEAR on the next edge.
REQ-022 SHALL hold stage_nrst=0 for exactly CLEAR_CYCLES cycles in CLEAR, then latch stage_mask and enter RUN at the lowest enabled stage.
REQ-023 SHALL go from CLEAR directly to END with exit_stage=0 if the latched mask is zero.
REQ-024 SHALL, in RUN at stage k, drive stage_en one-hot bit k-1, addr_select=k and stage_nrst=1.
REQ-025 SHALL, in RUN at stage k, drive wr_en = stage_wr_req[k-1]; requests from inactive stages are ignored.
REQ-026 SHALL, on stage_done[k-1]=1 with stage_exit[k-1]=1, enter END with exit_stage=k.
REQ-027 SHALL, on stage_done[k-1]=1 with stage_exit[k-1]=0, advance to the next enabled stage above k on the next edge, skipping masked stages, with no idle cycle.
REQ-028 SHALL, when stage k is the highest enabled stage, enter END with exit_stage=0 instead.
REQ-029 SHALL ignore done and exit bits of inactive stages.
REQ-030 SHALL run a 16-bit watchdog in RUN that clears on every stage change.
REQ-031 SHALL, when the watchdog reaches TIMEOUT-1 without done, pulse timeout and enter END with exit_stage=k.
REQ-032 SHALL give done priority over timeout on the same cycle.
REQ-033 SHALL, in END (one cycle), pulse round_done, drive stage_en=0 and addr_select=0, and increment round_count (wrapping 0xFFFF to 0) only when exit_stage=0.
REQ-034 SHALL leave END for CLEAR if run=1, else for IDLE.
REQ-035 SHALL finish a round started with run=1 even if run drops in RUN; run is only checked in IDLE and END.
REQ-036 SHALL hold exit_stage until the next END.

Reset
REQ-037 SHALL, on rst=1 and regardless of clock, set state IDLE, stage_en=0, stage_nrst=0, addr_select=0, wr_en=0, busy=0, round_done=0, timeout=0, exit_stage=0, round_count=0 and the watchdog to 0.
REQ-038 SHALL, on rst assertion mid-round, abort immediately, with no round_done pulse and no round_count change.
REQ-039 SHALL resume from IDLE on the first edge after rst deasserts.

Verification
REQ-040 SHALL be verified with: mask=0x7F, run=1, each stage done 3 cycles after enable with exit=0 -> addr_select steps 1..7, round_done pulses once, exit_stage=0, round_count=1, then a new CLEAR.
REQ-041 SHALL be verified with: mask=0x7F, stage 1 done with exit=1 -> END right after stage 1, exit_stage=1, stage 2 never enabled, round_count=0.
REQ-042 SHALL be verified with: mask=0x07, stage 3 asserts exit=1 -> addr_select goes 1, 2, 3, then 0; exit_stage=3; stages 4-7 never enabled.
REQ-043 SHALL be verified with: TIMEOUT=8, stage 2 never done -> timeout pulses exactly 8 cycles after stage 2 enable and exit_stage=2; with done and timeout on the same cycle, no timeout pulse.
REQ-044 SHALL be verified with: stage_wr_req=0x7F while stage 4 is active -> wr_en=1, and wr_en=0 whenever stage 4's request bit is cleared.
REQ-045 SHALL be verified with: rst pulsed while stage 5 is active -> all outputs reach their reset values before the next clock edge, and round_count is unchanged from 0.
